// File: rtl/calculator_core_if.sv
// Request/response bundle between the calculator front end and calculator_core.
// The master drives the operation request; the slave returns status and the result.
interface calculator_core_if #(
  parameter int unsigned WIDTH_OPERAND = 16,
  parameter int unsigned WIDTH_RESULT  = 32
);
  logic                     start;
  logic [2:0]               op;
  logic [WIDTH_OPERAND-1:0] a;
  logic [WIDTH_OPERAND-1:0] b;
  logic                     busy;
  logic                     done;
  logic [WIDTH_RESULT-1:0]  cal_result;
  logic                     err;

  modport master (
    output start, op, a, b,
    input  busy, done, cal_result, err
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, cal_result, err
  );
endinterface

// File: rtl/calculator_core.sv
// Multi-cycle unsigned arithmetic unit: one-cycle add/sub/logic/shift,
// bit-serial shift-add multiply and restoring divide, one-cycle done strobe.
module calculator_core #(
  parameter int unsigned WIDTH_OPERAND = 16,
  parameter int unsigned WIDTH_RESULT  = 32
) (
  input logic              clk,
  input logic              rst,
  calculator_core_if.slave bus
);
  localparam int unsigned W    = WIDTH_OPERAND;
  localparam int unsigned CntW = $clog2(W);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpMul = 3'b010;
  localparam logic [2:0] OpDiv = 3'b011;
  localparam logic [2:0] OpAnd = 3'b100;
  localparam logic [2:0] OpOr  = 3'b101;
  localparam logic [2:0] OpShl = 3'b110;
  localparam logic [2:0] OpRsv = 3'b111;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                  state_q, state_d;
  logic [2:0]              op_q;
  logic [W-1:0]            a_q, b_q;
  logic [2*W-1:0]          acc_q;
  logic [CntW-1:0]         cnt_q;
  logic [WIDTH_RESULT-1:0] result_q;
  logic                    err_q;

  logic                    is_iter, last_iter;
  logic [W:0]              mul_sum;
  logic [2*W-1:0]          mul_next;
  logic [W:0]              div_shift, div_diff;
  logic                    div_ge;
  logic [2*W-1:0]          div_next;
  logic [WIDTH_RESULT-1:0] a_ext, b_ext;
  logic [WIDTH_RESULT-1:0] calc_result;
  logic                    calc_err;

  assign is_iter   = (op_q == OpMul) || (op_q == OpDiv);
  assign last_iter = (cnt_q == CntW'(W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StCalc;
      StCalc:  if (!is_iter || last_iter) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // acc_q holds {partial product, remaining multiplier} for mul and
  // {partial remainder, dividend/quotient} for div; both start as {0, a}.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next  = {mul_sum, acc_q[W-1:1]};
    div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    div_diff  = div_shift - {1'b0, b_q};
    // No borrow out of the trial subtraction means the divisor fits.
    div_ge    = ~div_diff[W];
    div_next  = {(div_ge ? div_diff[W-1:0] : div_shift[W-1:0]), acc_q[W-2:0], div_ge};
  end

  assign a_ext = WIDTH_RESULT'(a_q);
  assign b_ext = WIDTH_RESULT'(b_q);

  always_comb begin
    calc_result = '0;
    unique case (op_q)
      OpAdd:   calc_result = a_ext + b_ext;
      OpSub:   calc_result = a_ext - b_ext;
      OpMul:   calc_result = WIDTH_RESULT'(mul_next);
      OpDiv:   calc_result = WIDTH_RESULT'({div_next[W-1:0], div_next[2*W-1:W]});
      OpAnd:   calc_result = a_ext & b_ext;
      OpOr:    calc_result = a_ext | b_ext;
      OpShl:   calc_result = a_ext << b_q[4:0];
      default: calc_result = '0;
    endcase
    calc_err = (op_q == OpRsv) || ((op_q == OpDiv) && (b_q == '0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            op_q  <= bus.op;
            a_q   <= bus.a;
            b_q   <= bus.b;
            acc_q <= {{W{1'b0}}, bus.a};
            cnt_q <= '0;
          end
        end
        StCalc: begin
          cnt_q <= cnt_q + CntW'(1);
          if (op_q == OpMul) acc_q <= mul_next;
          if (op_q == OpDiv) acc_q <= div_next;
          if (state_d == StDone) begin
            result_q <= calc_result;
            err_q    <= calc_err;
          end
        end
        StDone: err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.busy       = (state_q != StIdle);
  assign bus.done       = (state_q == StDone);
  assign bus.cal_result = result_q;
  assign bus.err        = err_q;
endmodule
